// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters.
// Round-robin grant, registered operands, registered response.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_src_a,
    input  logic [DATA_W-1:0] req0_src_b,
    input  logic [DATA_W-1:0] req1_src_a,
    input  logic [DATA_W-1:0] req1_src_b,
    input  logic [CTRL_W-1:0] req0_alu_ctrl,
    input  logic [CTRL_W-1:0] req1_alu_ctrl,
    output logic              resp0_valid,
    output logic              resp1_valid,
    input  logic              resp0_ready,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic [DATA_W-1:0] alu_src_a,
    output logic [DATA_W-1:0] alu_src_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_is_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic last_grant;
    logic grant_id;
    logic grant_sel;
    logic grant_any;
    logic accept;
    logic resp_fire;

    // Arbitration: a tie goes to the port that did not win last time
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = req1_valid;
        end
    end

    // Ready depends only on valids and state; held low during reset
    always_comb begin
        accept     = rst_n && (state_q == IDLE) && grant_any;
        req0_ready = accept && !grant_sel;
        req1_ready = accept && grant_sel;
        resp_fire  = (state_q == RESP) &&
                     (grant_id ? resp1_ready : resp0_ready);
        busy       = (state_q != IDLE);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and operand registers, loaded at grant time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            alu_src_a  <= '0;
            alu_src_b  <= '0;
            alu_ctrl   <= '0;
        end else if (accept) begin
            last_grant <= grant_sel;
            grant_id   <= grant_sel;
            alu_src_a  <= grant_sel ? req1_src_a : req0_src_a;
            alu_src_b  <= grant_sel ? req1_src_b : req0_src_b;
            alu_ctrl   <= grant_sel ? req1_alu_ctrl : req0_alu_ctrl;
        end
    end

    // Result capture after the ALU has settled for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_zero <= 1'b0;
        end else if (state_q == EXEC) begin
            resp_data <= alu_out;
            resp_zero <= alu_is_zero;
        end
    end

    // Registered response valids, steered by the recorded grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            resp0_valid <= (state_d == RESP) && !grant_id;
            resp1_valid <= (state_d == RESP) && grant_id;
        end
    end

    // Completed-operation counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (resp_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter.
// Driver pushes expected responses; monitor pops on handshake.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_src_a;
    logic [31:0] req0_src_b;
    logic [31:0] req1_src_a;
    logic [31:0] req1_src_b;
    logic [3:0]  req0_alu_ctrl;
    logic [3:0]  req1_alu_ctrl;
    logic        resp0_valid;
    logic        resp1_valid;
    logic        resp0_ready;
    logic        resp1_ready;
    logic [31:0] resp_data;
    logic        resp_zero;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        alu_is_zero;
    logic        busy;
    logic [3:0]  op_count;

    typedef struct {
        bit          port;
        logic [31:0] data;
        bit          zero;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   failed;
    logic [3:0] exp_cnt;

    alu_share_arbiter #(
        .DATA_W(32),
        .CTRL_W(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req1_valid(req1_valid),
        .req0_ready(req0_ready),
        .req1_ready(req1_ready),
        .req0_src_a(req0_src_a),
        .req0_src_b(req0_src_b),
        .req1_src_a(req1_src_a),
        .req1_src_b(req1_src_b),
        .req0_alu_ctrl(req0_alu_ctrl),
        .req1_alu_ctrl(req1_alu_ctrl),
        .resp0_valid(resp0_valid),
        .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready),
        .resp1_ready(resp1_ready),
        .resp_data(resp_data),
        .resp_zero(resp_zero),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl),
        .alu_out(alu_out),
        .alu_is_zero(alu_is_zero),
        .busy(busy),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU sitting behind the arbiter
    always_comb begin
        alu_out = 32'h0;
        case (alu_ctrl)
            4'b0000: alu_out = alu_src_a + alu_src_b;
            4'b0001: alu_out = alu_src_a - alu_src_b;
            4'b0010: alu_out = alu_src_a & alu_src_b;
            4'b0011: alu_out = alu_src_a | alu_src_b;
            4'b0100: alu_out = alu_src_a ^ alu_src_b;
            4'b0111: alu_out = $signed(alu_src_a) >>> alu_src_b[4:0];
            default: alu_out = 32'h0;
        endcase
        alu_is_zero = (alu_out == 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        failed++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        exp_t e;
        bit   gp;
        if (!rst_n) begin
            exp_cnt = 4'd0;
        end else begin
            if (resp0_valid && resp1_valid) begin
                chk("resp_both_valid", 32'(resp1_valid), 32'(1'b0));
            end
            if ((resp0_valid && resp0_ready) ||
                (resp1_valid && resp1_ready)) begin
                gp = resp1_valid;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 32'(1'b1), 32'(1'b0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", 32'(gp), 32'(e.port));
                    chk("resp_data", resp_data, e.data);
                    chk("resp_zero", 32'(resp_zero), 32'(e.zero));
                end
                chk("op_count", 32'(op_count), 32'(exp_cnt));
                exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    task automatic push(input bit p, input logic [31:0] d, input bit z);
        exp_t e;
        e.port = p;
        e.data = d;
        e.zero = z;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input bit p, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((p ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("req_ready_timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            fail_now("resp_timeout");
            sb.delete();
        end
    endtask

    task automatic drive(input bit p, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
        if (p) begin
            req1_valid    = 1'b1;
            req1_src_a    = a;
            req1_src_b    = b;
            req1_alu_ctrl = c;
        end else begin
            req0_valid    = 1'b1;
            req0_src_a    = a;
            req0_src_b    = b;
            req0_alu_ctrl = c;
        end
    endtask

    task automatic issue(input bit p, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c,
                         input logic [31:0] e, input bit z);
        bit ok;
        push(p, e, z);
        @(posedge clk);
        #1;
        drive(p, a, b, c);
        wait_ready(p, ok);
        @(posedge clk);
        #1;
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        if (ok) begin
            chk("alu_src_a", alu_src_a, a);
            chk("alu_src_b", alu_src_b, b);
            chk("alu_ctrl", 32'(alu_ctrl), 32'(c));
        end
        drain();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        bit order[4];
        int idx;
        int rem0;
        int rem1;
        bit a0;
        bit a1;
        tests = 0;
        failed = 0;
        exp_cnt = 4'd0;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_src_a = '0;
        req0_src_b = '0;
        req1_src_a = '0;
        req1_src_b = '0;
        req0_alu_ctrl = '0;
        req1_alu_ctrl = '0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_op_count", 32'(op_count), 32'(4'd0));
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'(4'd0));
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single port: port 1 sub 7-7
        issue(1'b1, 32'd7, 32'd7, 4'b0001, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        chk("single_op_count", 32'(op_count), 32'(4'd1));

        // Reset mid-EXEC discards the operation
        @(posedge clk);
        #1;
        drive(1'b0, 32'd9, 32'd9, 4'b0000);
        wait_ready(1'b0, ok);
        @(posedge clk);
        #1;
        chk("exec_busy", 32'(busy), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'(1'b0));
        chk("mid_alu_src_a", alu_src_a, 32'h0);
        chk("mid_alu_src_b", alu_src_b, 32'h0);
        chk("mid_resp_zero", 32'(resp_zero), 32'(1'b0));
        chk("mid_op_count", 32'(op_count), 32'(4'd0));
        chk("mid_req0_ready", 32'(req0_ready), 32'(1'b0));
        chk("mid_resp_valid", 32'({resp1_valid, resp0_valid}), 32'h0);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0);

        // Pass-through: sra and an undefined control code
        issue(1'b0, 32'h8000_0000, 32'd4, 4'b0111, 32'hF800_0000, 1'b0);
        issue(1'b1, 32'h1234_5678, 32'h1, 4'b1111, 32'h0, 1'b1);

        // Tie round-robin over four operations
        order[0] = 1'b0;
        order[1] = 1'b1;
        order[2] = 1'b0;
        order[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (order[i]) push(1'b1, 32'h0F0F_0F0F, 1'b0);
            else          push(1'b0, 32'd2, 1'b0);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 32'd1, 32'd1, 4'b0000);
        drive(1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'b0100);
        idx = 0;
        rem0 = 2;
        rem1 = 2;
        for (int i = 0; i < 100; i++) begin
            if (rem0 == 0 && rem1 == 0) break;
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            if (a0 && a1) chk("tie_both_ready", 32'(1'b1), 32'(1'b0));
            if ((a0 || a1) && idx < 4) begin
                chk("tie_grant_order", 32'(a1), 32'(order[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (a0) rem0--;
            if (a1) rem1--;
            if (rem0 <= 0) req0_valid = 1'b0;
            if (rem1 <= 0) req1_valid = 1'b0;
        end
        if (rem0 != 0 || rem1 != 0) fail_now("tie_timeout");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Back-pressure on port 0 while port 1 waits
        resp0_ready = 1'b0;
        push(1'b0, 32'd30, 1'b0);
        push(1'b1, 32'd7, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd10, 32'd20, 4'b0000);
        drive(1'b1, 32'd3, 32'd4, 4'b0000);
        wait_ready(1'b0, ok);
        chk("bp_req1_ready_at_grant", 32'(req1_ready), 32'(1'b0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp0_valid", 32'(resp0_valid), 32'(1'b1));
            chk("bp_resp_data", resp_data, 32'd30);
            chk("bp_req1_ready", 32'(req1_ready), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        resp0_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_req1_granted", 32'(req1_ready), 32'(1'b1));
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        drain();

        // Counter wrap after 16 operations
        do_reset();
        for (int i = 0; i < 16; i++) begin
            issue(i[0], 32'(i), 32'd1, 4'b0000, 32'(i + 1), 1'b0);
        end
        @(posedge clk);
        #1;
        chk("wrap_op_count", 32'(op_count), 32'(4'd0));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential front-end that shares one combinational ALU between two requesters, such as the execute stage and an address/branch helper. It arbitrates round-robin, registers the granted operands onto the ALU inputs, and captures the ALU result and zero flag. It returns them to the winning requester over a valid/ready handshake. It sits directly in front of the ALU: its `alu_*` outputs drive the ALU operand and control inputs, and the ALU result and zero flag feed back in.

## Interface
- `DATA_W`, 32, operand/result width
- `CTRL_W`, 4, ALU control code width
- `CNT_W`, 16, completed-operation counter width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid`, `req1_valid`  in  1  request present on port 0 / 1
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_src_a`, `req0_src_b`, `req1_src_a`, `req1_src_b`  in  DATA_W  operands
- `req0_alu_ctrl`, `req1_alu_ctrl`  in  CTRL_W  ALU operation code, passed through unmodified
- `resp0_valid`, `resp1_valid`  out  1  result available for port 0 / 1
- `resp0_ready`, `resp1_ready`  in  1  requester takes result
- `resp_data`  out  DATA_W  captured ALU result (shared by both ports)
- `resp_zero`  out  1  captured ALU zero flag
- `alu_src_a`, `alu_src_b`  out  DATA_W  to ALU operands
- `alu_ctrl`  out  CTRL_W  to ALU control
- `alu_out`  in  DATA_W  from ALU result
- `alu_is_zero`  in  1  from ALU zero flag
- `busy`  out  1  state != IDLE
- `op_count`  out  CNT_W  completed responses, wraps to 0 after all-ones

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `reqN_valid` is high, grant one port.
  - `reqN_ready` is high combinationally for the granted port only.
  - On the edge: latch src_a/src_b/alu_ctrl into the `alu_*` output registers, record `grant_id`, then go to EXEC.
  - With no valid request, stay in IDLE. `alu_*` registers hold their last values.
- **Arbitration:**
  - Only one port valid: grant that port.
  - Both ports valid: grant the port not recorded in `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `last_grant` updates at grant time.
- **EXEC:**
  - The ALU settles from the registered inputs.
  - On the edge: capture `alu_out` into `resp_data` and `alu_is_zero` into `resp_zero`, then go to RESP.
- **RESP:**
  - `respN_valid` is high only for N = `grant_id`.
  - `resp_data` and `resp_zero` hold stable.
  - When `respN_ready` is high for the granted port: go to IDLE, `resp_valid` drops next cycle, and `op_count` increments.
  - The other port's `resp_ready` is ignored.
- **Requester rules:**
  - Hold valid and payload stable until ready.
  - The block never accepts a new request outside IDLE, so both `req_ready` are 0 in EXEC and RESP.
  - Dropping valid before ready is legal; no grant occurs.
- **Width:**
  - Operands and control pass unmodified.
  - The block performs no arithmetic except the `op_count` increment, which is modulo 2^CNT_W.
- **Reset (asynchronous, active-low):**
  - State→IDLE, `alu_src_a`/`alu_src_b`/`alu_ctrl`→0, `resp_data`→0, `resp_zero`→0, `resp*_valid`→0, `busy`→0, `op_count`→0, `last_grant`→1, `grant_id`→0.
  - `req*_ready` is forced to 0 while `rst_n` is low.
  - An in-flight operation is discarded with no response. The requester must re-present it.

## Timing
- Request accepted at edge T (valid and ready both high).
- `alu_*` valid after edge T.
- Result captured at edge T+1.
- `resp_valid` high from after edge T+1 until the edge where `resp_ready` is seen.
- Minimum occupancy is 3 cycles per operation (grant, EXEC, RESP with ready already high). Peak throughput is 1 op per 3 cycles.
- `resp_ready` held high in RESP: response completes on the first RESP edge.
- Back-pressure: RESP holds indefinitely, and both requesters stall.
- `req_ready` depends combinationally on `req_valid` and state only; there is no path from `alu_out` to ready.
- `resp_valid` and `resp_data` are registered.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-EXEC → all outputs return to their reset values immediately. After release, port 0 re-requests add 5+3 → `resp0_valid` with `resp_data`=8, `resp_zero`=0.
- **Single port:** port 1 requests sub 7-7 (ctrl 0001), `resp1_ready`=1 → `req1_ready` at T, `resp1_valid` after T+1 with `resp_data`=0 and `resp_zero`=1. `op_count`=1; `resp0_valid` never asserts.
- **Tie round-robin:** both ports hold valid across 4 operations (port 0 add 1+1, port 1 xor F0F0F0F0^FFFFFFFF) → grant order 0,1,0,1 with results 2, 0F0F0F0F alternating.
- **Back-pressure:** `resp0_ready`=0 for 5 cycles → `resp0_valid` and `resp_data` stable, `req1_ready` stays 0 despite `req1_valid`=1. Port 1 is granted the cycle after the response completes.
- **Pass-through:** sra 80000000 by 4 (ctrl 0111) → `resp_data`=F8000000. Undefined ctrl 1111 → `alu_ctrl`=1111 driven and `resp_data`=0.
- **Counter wrap:** CNT_W=4, run 16 operations → `op_count` reads 0 after the 16th response.
